// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, byte-order constant and clog2 helper for the byte/word FIFOs
package fifo_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // Byte order on the wire. Shared with the 16-to-8 unpacker so that both
    // ends of the byte stream agree on which half of a word travels first.
    localparam bit MSB_FIRST = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_word.sv
// rtl/sync_fifo_word.sv - single-clock word FIFO with registered read data
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   wr_en, wr_data    word write; ignored while full
//   rd_en, rd_data    word read; rd_data loads mem[rptr] on an accepted read
//                     and holds otherwise; ignored while empty
//   count             stored words, 0..DEPTH_WORDS
//   empty, full       derived from count
module sync_fifo_word
    import fifo_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = clog2(DEPTH_WORDS)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              full
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH_WORDS);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              wr_ok;
    logic              rd_ok;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr    <= rptr + PTR_ONE;
                rd_data <= mem[rptr];
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_pack8to16.sv
// rtl/fifo_pack8to16.sv - byte-in, word-out FIFO: pairs bytes into 16-bit words
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset (highest priority)
//   Wen, Din, Full    byte write side; Full blocks a byte
//   Ren, Dout, Empty  word read side; Dout registered, 1-cycle latency
//   Word_count        complete words stored
//   Half_pending      one byte waiting in the hold register for its partner
//   Flush             discard the pending byte; stored words untouched
//   Ovf, Udf          sticky write-while-Full / read-while-Empty, cleared by Rst
module fifo_pack8to16
    import fifo_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = clog2(DEPTH_WORDS)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Wen,
    input  logic [BYTE_W-1:0] Din,
    output logic              Full,
    input  logic              Ren,
    output logic [WORD_W-1:0] Dout,
    output logic              Empty,
    output logic [AW:0]       Word_count,
    output logic              Half_pending,
    input  logic              Flush,
    output logic              Ovf,
    output logic              Udf
);

    logic [BYTE_W-1:0] hold;
    logic              store_full;
    logic              byte_ok;
    logic              pair_open;
    logic              word_wr;
    logic [WORD_W-1:0] word_data;

    // With storage full but nothing pending, one more byte still fits in the
    // hold register; only the byte that would complete a word is refused.
    assign Full = store_full && Half_pending;

    assign byte_ok = Wen && !Full;

    // Flush makes a simultaneous byte start a fresh pair instead of closing
    // the old one.
    assign pair_open = Half_pending && !Flush;
    assign word_wr   = byte_ok && pair_open;

    assign word_data = MSB_FIRST ? {hold, Din} : {Din, hold};

    sync_fifo_word #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_words (
        .Clk    (Clk),
        .Rst    (Rst),
        .wr_en  (word_wr),
        .wr_data(word_data),
        .rd_en  (Ren),
        .rd_data(Dout),
        .count  (Word_count),
        .empty  (Empty),
        .full   (store_full)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold         <= '0;
            Half_pending <= 1'b0;
        end else if (byte_ok) begin
            if (pair_open) begin
                Half_pending <= 1'b0;
            end else begin
                hold         <= Din;
                Half_pending <= 1'b1;
            end
        end else if (Flush) begin
            Half_pending <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Ovf <= 1'b0;
            Udf <= 1'b0;
        end else begin
            if (Wen && Full) begin
                Ovf <= 1'b1;
            end
            if (Ren && Empty) begin
                Udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pack8to16.sv
// tb/tb_fifo_pack8to16.sv - directed vector table plus corner-case sequences for fifo_pack8to16
module tb_fifo_pack8to16;

    logic        Clk;
    logic        Rst;
    logic        Wen;
    logic [7:0]  Din;
    logic        Full;
    logic        Ren;
    logic [15:0] Dout;
    logic        Empty;
    logic [9:0]  Word_count;
    logic        Half_pending;
    logic        Flush;
    logic        Ovf;
    logic        Udf;

    int tests;
    int failed;

    fifo_pack8to16 #(.DEPTH_WORDS(512), .AW(9)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Wen         (Wen),
        .Din         (Din),
        .Full        (Full),
        .Ren         (Ren),
        .Dout        (Dout),
        .Empty       (Empty),
        .Word_count  (Word_count),
        .Half_pending(Half_pending),
        .Flush       (Flush),
        .Ovf         (Ovf),
        .Udf         (Udf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        wen;
        logic [7:0]  din;
        logic        ren;
        logic        flush;
        logic        e_empty;
        logic        e_full;
        logic [9:0]  e_cnt;
        logic        e_half;
        logic [15:0] e_dout;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic wen, input logic [7:0] din,
                       input logic ren, input logic flush,
                       input logic e_empty, input logic e_full, input logic [9:0] e_cnt,
                       input logic e_half, input logic [15:0] e_dout,
                       input logic e_ovf, input logic e_udf);
        vec_t v;
        v.rst = rst; v.wen = wen; v.din = din; v.ren = ren; v.flush = flush;
        v.e_empty = e_empty; v.e_full = e_full; v.e_cnt = e_cnt; v.e_half = e_half;
        v.e_dout = e_dout; v.e_ovf = e_ovf; v.e_udf = e_udf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic rst, input logic wen, input logic [7:0] din,
                        input logic ren, input logic flush);
        @(negedge Clk);
        Rst = rst; Wen = wen; Din = din; Ren = ren; Flush = flush;
        @(posedge Clk);
        #1;
    endtask

    logic [15:0] model_q[$];
    int          mcnt;
    logic        mhalf;
    logic [7:0]  mhold;
    logic [15:0] exp_word;
    int          words_written;
    int          cyc;
    logic        w_r;
    logic        r_r;
    logic [7:0]  d_r;

    initial begin
        tests = 0;
        failed = 0;
        Rst = 1'b1; Wen = 1'b0; Din = 8'h00; Ren = 1'b0; Flush = 1'b0;

        //   rst wen din    ren fl | emp full cnt half dout     ovf udf
        add(1, 0, 8'h00, 0, 0,   1, 0, 0, 0, 16'h0000, 0, 0);
        add(0, 1, 8'hA1, 0, 0,   1, 0, 0, 1, 16'h0000, 0, 0);
        add(0, 1, 8'hB2, 0, 0,   0, 0, 1, 0, 16'h0000, 0, 0);
        add(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 16'hA1B2, 0, 0);
        add(0, 0, 8'h00, 0, 0,   1, 0, 0, 0, 16'hA1B2, 0, 0);
        add(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 16'hA1B2, 0, 1);
        add(0, 1, 8'hC3, 0, 0,   1, 0, 0, 1, 16'hA1B2, 0, 1);
        add(1, 1, 8'hD4, 1, 1,   1, 0, 0, 0, 16'h0000, 0, 0);
        add(0, 1, 8'h11, 0, 0,   1, 0, 0, 1, 16'h0000, 0, 0);
        add(0, 0, 8'h00, 0, 1,   1, 0, 0, 0, 16'h0000, 0, 0);
        add(0, 1, 8'h22, 0, 0,   1, 0, 0, 1, 16'h0000, 0, 0);
        add(0, 1, 8'h33, 0, 0,   0, 0, 1, 0, 16'h0000, 0, 0);
        add(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 16'h2233, 0, 0);
        add(0, 1, 8'h44, 0, 0,   1, 0, 0, 1, 16'h2233, 0, 0);
        add(0, 1, 8'h55, 0, 1,   1, 0, 0, 1, 16'h2233, 0, 0);
        add(0, 1, 8'h66, 0, 0,   0, 0, 1, 0, 16'h2233, 0, 0);
        add(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 16'h5566, 0, 0);
        add(0, 1, 8'h01, 0, 0,   1, 0, 0, 1, 16'h5566, 0, 0);
        add(0, 1, 8'h02, 0, 0,   0, 0, 1, 0, 16'h5566, 0, 0);
        add(0, 1, 8'h03, 0, 0,   0, 0, 1, 1, 16'h5566, 0, 0);
        add(0, 1, 8'h04, 0, 0,   0, 0, 2, 0, 16'h5566, 0, 0);
        add(0, 1, 8'h05, 0, 0,   0, 0, 2, 1, 16'h5566, 0, 0);
        add(0, 1, 8'h06, 0, 0,   0, 0, 3, 0, 16'h5566, 0, 0);
        add(0, 1, 8'h07, 0, 0,   0, 0, 3, 1, 16'h5566, 0, 0);
        add(0, 1, 8'h08, 1, 0,   0, 0, 3, 0, 16'h0102, 0, 0);
        add(0, 0, 8'h00, 1, 0,   0, 0, 2, 0, 16'h0304, 0, 0);
        add(0, 0, 8'h00, 1, 0,   0, 0, 1, 0, 16'h0506, 0, 0);
        add(0, 0, 8'h00, 1, 0,   1, 0, 0, 0, 16'h0708, 0, 0);
        add(0, 1, 8'h09, 0, 0,   1, 0, 0, 1, 16'h0708, 0, 0);
        add(0, 1, 8'h0A, 0, 0,   0, 0, 1, 0, 16'h0708, 0, 0);
        add(0, 1, 8'h0B, 0, 0,   0, 0, 1, 1, 16'h0708, 0, 0);
        add(0, 0, 8'h00, 1, 1,   1, 0, 0, 0, 16'h090A, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wen, vecs[i].din, vecs[i].ren, vecs[i].flush);
            check($sformatf("v%0d empty", i), 32'(Empty),        32'(vecs[i].e_empty));
            check($sformatf("v%0d full", i),  32'(Full),         32'(vecs[i].e_full));
            check($sformatf("v%0d count", i), 32'(Word_count),   32'(vecs[i].e_cnt));
            check($sformatf("v%0d half", i),  32'(Half_pending), 32'(vecs[i].e_half));
            check($sformatf("v%0d dout", i),  32'(Dout),         32'(vecs[i].e_dout));
            check($sformatf("v%0d ovf", i),   32'(Ovf),          32'(vecs[i].e_ovf));
            check($sformatf("v%0d udf", i),   32'(Udf),          32'(vecs[i].e_udf));
        end

        // Fill to capacity: 1024 bytes fill storage, the 1025th waits in hold.
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 1025; i++) begin
            step(0, 1, i[7:0], 0, 0);
            if (i == 1023) begin
                check("fill1024 count", 32'(Word_count), 32'd512);
                check("fill1024 full", 32'(Full), 32'd0);
            end
        end
        check("fill count", 32'(Word_count), 32'd512);
        check("fill half", 32'(Half_pending), 32'd1);
        check("fill full", 32'(Full), 32'd1);
        check("fill ovf", 32'(Ovf), 32'd0);
        step(0, 1, 8'hFF, 0, 0);
        check("over ovf", 32'(Ovf), 32'd1);
        check("over count", 32'(Word_count), 32'd512);
        check("over half", 32'(Half_pending), 32'd1);
        for (int k = 0; k < 512; k++) begin
            step(0, 0, 8'h00, 1, 0);
            exp_word = {8'(2 * k), 8'(2 * k + 1)};
            check($sformatf("drain w%0d", k), 32'(Dout), 32'(exp_word));
        end
        check("drain empty", 32'(Empty), 32'd1);
        check("drain count", 32'(Word_count), 32'd0);
        check("drain half", 32'(Half_pending), 32'd1);
        check("drain udf", 32'(Udf), 32'd0);

        // Random interleaved stream against a byte-level model.
        step(1, 0, 8'h00, 0, 0);
        mcnt = 0; mhalf = 1'b0; mhold = 8'h00; words_written = 0; cyc = 0;
        model_q.delete();
        while (words_written < 2000 && cyc < 30000) begin
            cyc = cyc + 1;
            w_r = ($urandom_range(0, 1) == 1) && !(mcnt == 512 && mhalf);
            r_r = ($urandom_range(0, 1) == 1) && (mcnt != 0);
            d_r = 8'($urandom_range(0, 255));
            step(0, w_r, d_r, r_r, 0);
            if (r_r) begin
                exp_word = model_q.pop_front();
                mcnt = mcnt - 1;
                check("stream dout", 32'(Dout), 32'(exp_word));
            end
            if (w_r) begin
                if (mhalf) begin
                    model_q.push_back({mhold, d_r});
                    mcnt = mcnt + 1;
                    words_written = words_written + 1;
                    mhalf = 1'b0;
                end else begin
                    mhold = d_r;
                    mhalf = 1'b1;
                end
            end
            check("stream count", 32'(Word_count), 32'(mcnt));
            check("stream half", 32'(Half_pending), 32'(mhalf));
        end
        check("stream done", 32'(words_written), 32'd2000);
        check("stream ovf", 32'(Ovf), 32'd0);
        check("stream udf", 32'(Udf), 32'd0);

        // Reset mid-stream with words and a pending byte present.
        step(0, 1, 8'h5A, 0, 0);
        step(0, 1, 8'hA5, 1, 0);
        step(0, 1, 8'h3C, 0, 0);
        step(1, 1, 8'hC3, 1, 0);
        check("rst empty", 32'(Empty), 32'd1);
        check("rst count", 32'(Word_count), 32'd0);
        check("rst dout", 32'(Dout), 32'd0);
        check("rst half", 32'(Half_pending), 32'd0);
        check("rst full", 32'(Full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
